// File: rtl/store_align_buffer_if.sv
// Store request and data-memory write bundle for store_align_buffer.
// master drives requests and memory ready; slave is the buffer.
interface store_align_buffer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        buf_empty;
  logic        addr_err;
  logic [31:0] err_addr;

  modport master (
    output req_valid, req_memop, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
    input  buf_empty, addr_err, err_addr
  );

  modport slave (
    input  req_valid, req_memop, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
    output buf_empty, addr_err, err_addr
  );
endinterface

// File: rtl/store_align_buffer.sv
// Store lane alignment (sb/sh/sw/swl/swr) feeding a small write FIFO.
// Define STORE_ALIGN_CHECK_EN to drop and flag misaligned sh/sw.
module store_align_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  store_align_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_SWL = 4'b1011;
  localparam logic [3:0] OP_SWR = 4'b1101;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             addr_err_q, addr_err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [1:0]  a;
  logic [31:0] d;
  logic        is_store;
  logic        misal;
  logic        ready;
  logic        acc;
  logic        push;
  logic        pop;
  logic [3:0]  cv_be;
  logic [31:0] cv_wdata;

  always_comb begin
    a        = bus.req_addr[1:0];
    d        = bus.req_data;
    is_store = 1'b1;
    cv_be    = '0;
    cv_wdata = '0;
    unique case (1'b1)
      bus.req_memop == OP_SB: begin
        cv_be    = 4'b1000 >> a;
        cv_wdata = {4{d[7:0]}};
      end
      bus.req_memop == OP_SH: begin
        cv_be    = a[1] ? 4'b0011 : 4'b1100;
        cv_wdata = {2{d[15:0]}};
      end
      bus.req_memop == OP_SW: begin
        cv_be    = 4'b1111;
        cv_wdata = d;
      end
      bus.req_memop == OP_SWL: begin
        cv_be    = 4'b1111 >> a;
        cv_wdata = d >> {a, 3'b000};
      end
      // 3-a on two bits is ~a
      bus.req_memop == OP_SWR: begin
        cv_be    = 4'b1111 << ~a;
        cv_wdata = d << {~a, 3'b000};
      end
      default: is_store = 1'b0;
    endcase
  end

  always_comb begin
    ready = (cnt_q != FULL);
    acc   = bus.req_valid && ready;
`ifdef STORE_ALIGN_CHECK_EN
    misal = ((bus.req_memop == OP_SH) && a[0]) ||
            ((bus.req_memop == OP_SW) && (a != 2'b00));
    addr_err_d = acc && misal;
    err_addr_d = (acc && misal) ? bus.req_addr : err_addr_q;
`else
    misal      = 1'b0;
    addr_err_d = 1'b0;
    err_addr_d = '0;
`endif
    push   = acc && is_store && !misal;
    pop    = (cnt_q != '0) && bus.mem_ready;
    ent_d  = ent_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      ent_d[wptr_q] = '{addr: bus.req_addr[31:2],
                        wdata: cv_wdata, be: cv_be};
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      ent_q      <= ent_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_valid = (cnt_q != '0);
  assign bus.buf_empty = (cnt_q == '0);
  assign bus.mem_addr  = ent_q[rptr_q].addr;
  assign bus.mem_wdata = ent_q[rptr_q].wdata;
  assign bus.mem_be    = ent_q[rptr_q].be;
  assign bus.addr_err  = addr_err_q;
  assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_store_align_buffer.sv
// Directed plus random bench for store_align_buffer.
// Reference model: per-byte-lane store rules and a queue.
module tb_store_align_buffer;
  localparam int DEPTH = 2;
  localparam logic [3:0] SB  = 4'b1000;
  localparam logic [3:0] SH  = 4'b1001;
  localparam logic [3:0] SW  = 4'b1010;
  localparam logic [3:0] SWL = 4'b1011;
  localparam logic [3:0] SWR = 4'b1101;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  logic        exp_err = 1'b0;
  logic [31:0] exp_eaddr = '0;
  logic [3:0]  ops [7];

  always #5 clk = ~clk;

  store_align_buffer_if bus ();

  store_align_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte lane i is address offset i, i.e. wdata[31-8i -: 8] and be[3-i].
  function automatic void conv(input logic [3:0] op,
                               input logic [31:0] ad,
                               input logic [31:0] dv,
                               output logic st, output logic bad,
                               output exp_t e);
    int a;
    logic [7:0] b [4];
    logic en;
    logic [7:0] v;
    a = int'(ad[1:0]);
    for (int k = 0; k < 4; k++) b[k] = dv[31-8*k -: 8];
    st = 1'b1;
    bad = 1'b0;
    e.addr = ad[31:2];
    e.be = '0;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      en = 1'b0;
      v = '0;
      case (op)
        SB:  begin v = b[3]; en = (i == a); end
        SH:  begin v = b[2 + (i % 2)]; en = (i / 2 == a / 2); end
        SW:  begin v = b[i]; en = 1'b1; end
        SWL: begin en = (i >= a); if (en) v = b[i - a]; end
        SWR: begin en = (i <= a); if (en) v = b[3 - a + i]; end
        default: st = 1'b0;
      endcase
      e.be[3-i] = en;
      e.wdata[31-8*i -: 8] = v;
    end
`ifdef STORE_ALIGN_CHECK_EN
    bad = ((op == SH) && ad[0]) || ((op == SW) && (ad[1:0] != 2'b00));
`endif
  endfunction

  task automatic check_outputs();
    chk("mem_valid", 32'(bus.mem_valid), 32'(q.size() != 0));
    chk("buf_empty", 32'(bus.buf_empty), 32'(q.size() == 0));
    chk("req_ready", 32'(bus.req_ready), 32'(q.size() < DEPTH));
    chk("addr_err", 32'(bus.addr_err), 32'(exp_err));
    chk("err_addr", bus.err_addr, exp_eaddr);
    if (q.size() != 0) begin
      chk("head_addr", 32'(bus.mem_addr), 32'(q[0].addr));
      chk("head_wdata", bus.mem_wdata, q[0].wdata);
      chk("head_be", 32'(bus.mem_be), 32'(q[0].be));
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic v, input logic [3:0] op,
                      input logic [31:0] ad, input logic [31:0] dv,
                      input logic mr);
    logic st, bad, acc, pop;
    exp_t e;
    @(negedge clk);
    check_outputs();
    bus.req_valid = v;
    bus.req_memop = op;
    bus.req_addr = ad;
    bus.req_data = dv;
    bus.mem_ready = mr;
    conv(op, ad, dv, st, bad, e);
    acc = v && (q.size() < DEPTH);
    pop = (q.size() != 0) && mr;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc && st && !bad) q.push_back(e);
    exp_err = acc && st && bad;
    if (acc && st && bad) exp_eaddr = ad;
    #1;
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    repeat (cyc) @(posedge clk);
    q.delete();
    exp_err = 1'b0;
    exp_eaddr = '0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_memop = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.mem_ready = 1'b0;
    ops = '{SB, SH, SW, SWL, SWR, 4'b0000, 4'b1100};

    do_reset(2);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_buf_empty", 32'(bus.buf_empty), 32'd1);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
    chk("rst_err_addr", bus.err_addr, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);

    step(1'b1, SB, 32'h103, 32'h11223344, 1'b1);
    chk("sb_addr", 32'(bus.mem_addr), 32'h40);
    chk("sb_be", 32'(bus.mem_be), 32'b0001);
    chk("sb_wdata", bus.mem_wdata, 32'h44444444);
    step(1'b1, SH, 32'h102, 32'h11223344, 1'b1);
    chk("sh_be", 32'(bus.mem_be), 32'b0011);
    chk("sh_wdata", bus.mem_wdata, 32'h33443344);
    step(1'b1, SWL, 32'h201, 32'hAABBCCDD, 1'b1);
    chk("swl_be", 32'(bus.mem_be), 32'b0111);
    chk("swl_wdata", bus.mem_wdata, 32'h00AABBCC);
    step(1'b1, SWR, 32'h201, 32'hAABBCCDD, 1'b1);
    chk("swr_be", 32'(bus.mem_be), 32'b1100);
    chk("swr_wdata", bus.mem_wdata, 32'hCCDD0000);
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    chk("drained", 32'(bus.buf_empty), 32'd1);

    step(1'b1, SW, 32'h400, 32'hA1, 1'b0);
    step(1'b1, SW, 32'h404, 32'hA2, 1'b0);
    chk("bp_full_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_head0", 32'(bus.mem_addr), 32'h100);
    step(1'b1, SW, 32'h408, 32'hA3, 1'b0);
    chk("bp_hold", 32'(bus.mem_addr), 32'h100);
    chk("bp_hold_data", bus.mem_wdata, 32'hA1);
    step(1'b1, SW, 32'h408, 32'hA3, 1'b1);
    chk("bp_pop1", 32'(bus.mem_addr), 32'h101);
    chk("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
    step(1'b1, SW, 32'h408, 32'hA3, 1'b1);
    chk("bp_pop2", 32'(bus.mem_addr), 32'h102);
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    chk("bp_empty", 32'(bus.buf_empty), 32'd1);

    step(1'b1, SW, 32'h500, 32'h1, 1'b0);
    step(1'b1, SW, 32'h504, 32'h2, 1'b0);
    do_reset(1);
    chk("midrst_valid", 32'(bus.mem_valid), 32'd0);
    chk("midrst_empty", 32'(bus.buf_empty), 32'd1);
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);

    step(1'b1, SW, 32'h302, 32'hDEADBEEF, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
    chk("al_err", 32'(bus.addr_err), 32'd1);
    chk("al_err_addr", bus.err_addr, 32'h302);
    chk("al_not_enq", 32'(bus.mem_valid), 32'd0);
`else
    chk("al_enq", 32'(bus.mem_valid), 32'd1);
    chk("al_addr", 32'(bus.mem_addr), 32'hC0);
    chk("al_be", 32'(bus.mem_be), 32'b1111);
`endif
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    chk("al_pulse_end", 32'(bus.addr_err), 32'd0);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 6)],
           $urandom, $urandom, $urandom_range(0, 4) < 3);
    end
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
